// File: rtl/decod_prioridade4x16_seq.sv
// decod_prioridade4x16_seq
// Receiving end of the 16x4 priority-encoder link. The transmitter sends
// one 4-bit code per set bit of its request vector. This block one-hot
// decodes each code, ORs it into an accumulator, and keeps a population
// count. On the beat marked last, it presents the rebuilt vector.
//
// Optional build macro ORDER_CHECK_EN enables a check of the code order.
// A frame is out of order if its codes are not strictly descending, or if
// an in_none beat follows a real code. Such a frame is reported on
// out_err. When the macro is undefined, out_err is tied low.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous reset, active-high
//   in_valid   code beat valid
//   in_ready   block can accept a beat (low while a vector is held)
//   in_code    encoded bit index
//   in_none    beat carries no bit; in_code ignored
//   in_last    final beat of the frame
//   out_valid  rebuilt vector available
//   out_ready  consumer accepts vector
//   out_vec    rebuilt vector
//   out_count  number of set bits in out_vec (0..16)
//   out_err    ordering error flag for the presented vector
module decod_prioridade4x16_seq #(
  parameter int CODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [CODE_W-1:0]   in_code,
  input  logic                in_none,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2**CODE_W-1:0] out_vec,
  output logic [CODE_W:0]     out_count,
  output logic                out_err
);

  localparam int VEC_W = 2**CODE_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [VEC_W-1:0]   acc_q, acc_d;
  logic [CODE_W:0]    cnt_q, cnt_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [CODE_W:0]    count_q, count_d;
  logic [VEC_W-1:0]   onehot;
  logic               accept;

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign out_vec   = vec_q;
  assign out_count = count_q;
  assign accept    = in_valid & in_ready;
  assign onehot    = VEC_W'(1) << in_code;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      vec_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      vec_q   <= vec_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    vec_d   = vec_q;
    count_d = count_q;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!in_none) begin
            acc_d = acc_q | onehot;
            // A repeated code must not be counted a second time.
            if ((acc_q & onehot) == '0)
              cnt_d = cnt_q + (CODE_W+1)'(1);
          end
          if (in_last) begin
            // The output loads the updated values, so the last beat is
            // included in the vector presented on the next cycle.
            state_d = HOLD;
            vec_d   = acc_d;
            count_d = cnt_d;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef ORDER_CHECK_EN
  logic [CODE_W-1:0] prev_q, prev_d;
  logic              have_q, have_d;   // prev_q holds a code from this frame
  logic              err_q, err_d;     // sticky error for the current frame
  logic              oerr_q, oerr_d;
  logic              err_now;

  assign out_err = oerr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= '0;
      have_q <= 1'b0;
      err_q  <= 1'b0;
      oerr_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
      have_q <= have_d;
      err_q  <= err_d;
      oerr_q <= oerr_d;
    end
  end

  always_comb begin
    prev_d  = prev_q;
    have_d  = have_q;
    err_d   = err_q;
    oerr_d  = oerr_q;
    err_now = 1'b0;
    case (state_q)
      IDLE, ACCUM: begin
        if (accept) begin
          if (!in_none) begin
            if ((state_q == ACCUM) && have_q && (in_code >= prev_q))
              err_now = 1'b1;
            prev_d = in_code;
            have_d = 1'b1;
          end else if (have_q) begin
            err_now = 1'b1;
          end
          if (in_last) begin
            // The error from the last beat itself must reach out_err.
            oerr_d = err_q | err_now;
            err_d  = 1'b0;
            have_d = 1'b0;
          end else begin
            err_d = err_q | err_now;
          end
        end
      end
      HOLD: begin
        if (out_ready)
          oerr_d = 1'b0;
      end
      default: begin
        err_d  = 1'b0;
        have_d = 1'b0;
      end
    endcase
  end
`else
  assign out_err = 1'b0;
`endif

endmodule
